// File: rtl/rank_pkg.sv
// Shared types and constants for the alphabet ranking sequencer.
package rank_pkg;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_NUM_ENTRIES = 26;

  // Polarity of the memory mem_rw_ strobe.
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/abs_diff.sv
// Two's-complement magnitude of a subtractor result.
// A set borrow-out means X<Y, so the raw difference is negative and
// is negated; the result is truncated to DATA_W bits.
module abs_diff #(
  parameter int DATA_W = 12
) (
  input  logic [DATA_W-1:0] i_diff,
  input  logic              i_bout,
  output logic [DATA_W-1:0] o_abs
);

  logic [DATA_W-1:0] w_neg;

  assign w_neg = (~i_diff) + {{(DATA_W-1){1'b0}}, 1'b1};
  assign o_abs = i_bout ? w_neg : i_diff;

endmodule

// File: rtl/rank_sequencer.sv
// Controller for the alphabet ranking datapath: streams (X,Y) pairs into an
// external subtractor, stores each |X-Y| at consecutive memory addresses,
// then scans the stored words and reports the index/value of the minimum.
module rank_sequencer
  import rank_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              in_ready,
  output logic              sub_de,
  output logic [DATA_W-1:0] sub_x,
  output logic [DATA_W-1:0] sub_y,
  output logic              sub_bin,
  input  logic              sub_oe,
  input  logic [DATA_W-1:0] sub_diff,
  input  logic              sub_bout,
  output logic              mem_cs,
  output logic              mem_rw_,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] best_idx,
  output logic [DATA_W-1:0] best_diff,
  output logic              err_overflow
);

  // Counters must be able to hold NUM_ENTRIES itself, which may equal 2**ADDR_W.
  localparam int               CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_ENTRIES);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_sub_de;
  logic [DATA_W-1:0] r_sub_x;
  logic [DATA_W-1:0] r_sub_y;
  logic              r_mem_cs;
  logic              r_mem_rw_;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_best_idx;
  logic [DATA_W-1:0] r_best_diff;
  logic              r_err_overflow;

  logic [CNT_W-1:0]  r_acc_cnt;   // pairs accepted this frame
  logic [CNT_W-1:0]  r_wr_idx;    // writes issued this frame
  logic [CNT_W-1:0]  r_rd_idx;    // next read address during SCAN
  logic              r_cmp_valid; // mem_rdata holds a word to compare
  logic [ADDR_W-1:0] r_cmp_idx;   // address that word was read from

  logic              w_accept;
  logic              w_res_valid;
  logic [DATA_W-1:0] w_abs;
  logic [CNT_W-1:0]  w_acc_next;
  logic              w_frame_end;
  logic              w_rd_more;
  logic              w_better;
  logic              w_last_cmp;

  abs_diff #(
    .DATA_W (DATA_W)
  ) u_abs_diff (
    .i_diff (sub_diff),
    .i_bout (sub_bout),
    .o_abs  (w_abs)
  );

  assign w_accept    = (r_state == LOAD) && r_in_ready && in_valid;
  // Results are only meaningful while a frame is being loaded or drained.
  assign w_res_valid = !sub_oe && ((r_state == LOAD) || (r_state == DRAIN));
  assign w_acc_next  = r_acc_cnt + 1'b1;
  assign w_frame_end = in_last || (w_acc_next == MAX_CNT);
  assign w_rd_more   = (r_rd_idx < r_acc_cnt);
  // Strictly-less keeps the lower index on ties.
  assign w_better    = r_cmp_valid && (mem_rdata < r_best_diff);
  assign w_last_cmp  = r_cmp_valid && ({1'b0, r_cmp_idx} == (r_acc_cnt - 1'b1));

  // Frame sequencer: single FSM owning every registered output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state        <= IDLE;
      r_in_ready     <= 1'b0;
      r_sub_de       <= 1'b1;
      r_sub_x        <= '0;
      r_sub_y        <= '0;
      r_mem_cs       <= 1'b0;
      r_mem_rw_      <= MEM_READ;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_best_idx     <= '0;
      r_best_diff    <= '0;
      r_err_overflow <= 1'b0;
      r_acc_cnt      <= '0;
      r_wr_idx       <= '0;
      r_rd_idx       <= '0;
      r_cmp_valid    <= 1'b0;
      r_cmp_idx      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values and later assignments override these
      // per-cycle defaults without ordering hazards.
      r_done   <= 1'b0;
      r_sub_de <= 1'b1;
      r_mem_cs <= 1'b0;

      // A read visible on the bus this cycle returns data next cycle.
      r_cmp_valid <= (r_state == SCAN) && r_mem_cs && (r_mem_rw_ == MEM_READ);
      r_cmp_idx   <= r_mem_addr;

      // Write path: one memory write per subtractor result, in order.
      if (w_res_valid) begin
        r_mem_cs    <= 1'b1;
        r_mem_rw_   <= MEM_WRITE;
        r_mem_addr  <= r_wr_idx[ADDR_W-1:0];
        r_mem_wdata <= w_abs;
        r_wr_idx    <= r_wr_idx + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state        <= LOAD;
            r_in_ready     <= 1'b1;
            r_busy         <= 1'b1;
            r_acc_cnt      <= '0;
            r_wr_idx       <= '0;
            r_err_overflow <= 1'b0;
            r_best_diff    <= '1;
            r_best_idx     <= '0;
          end
        end

        LOAD: begin
          if (w_accept) begin
            r_sub_x   <= in_x;
            r_sub_y   <= in_y;
            r_sub_de  <= 1'b0;
            r_acc_cnt <= w_acc_next;
            if (w_frame_end) begin
              r_in_ready     <= 1'b0;
              r_state        <= DRAIN;
              // Only a full frame without in_last is an overflow.
              r_err_overflow <= !in_last;
            end
          end
        end

        DRAIN: begin
          // Every accepted pair has been written; start scanning at address 0.
          if (r_wr_idx == r_acc_cnt) begin
            r_state    <= SCAN;
            r_mem_cs   <= 1'b1;
            r_mem_rw_  <= MEM_READ;
            r_mem_addr <= '0;
            r_rd_idx   <= CNT_W'(1);
          end
        end

        SCAN: begin
          if (w_better) begin
            r_best_diff <= mem_rdata;
            r_best_idx  <= r_cmp_idx;
          end
          if (w_rd_more) begin
            r_mem_cs   <= 1'b1;
            r_mem_rw_  <= MEM_READ;
            r_mem_addr <= r_rd_idx[ADDR_W-1:0];
            r_rd_idx   <= r_rd_idx + 1'b1;
          end
          if (w_last_cmp) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign sub_de       = r_sub_de;
  assign sub_x        = r_sub_x;
  assign sub_y        = r_sub_y;
  assign sub_bin      = 1'b0;
  assign mem_cs       = r_mem_cs;
  assign mem_rw_      = r_mem_rw_;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign busy         = r_busy;
  assign done         = r_done;
  assign best_idx     = r_best_idx;
  assign best_diff    = r_best_diff;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_rank_sequencer.sv
// Directed bench for rank_sequencer with a 1-cycle subtractor model, a
// registered-read memory model and a write scoreboard.
module tb_rank_sequencer;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 6;
  localparam int NUM_E  = 4;

  logic              CLK;
  logic              RST;
  logic              start;
  logic              in_valid;
  logic              in_last;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic              in_ready;
  logic              sub_de;
  logic [DATA_W-1:0] sub_x;
  logic [DATA_W-1:0] sub_y;
  logic              sub_bin;
  logic              sub_oe;
  logic [DATA_W-1:0] sub_diff;
  logic              sub_bout;
  logic              mem_cs;
  logic              mem_rw_;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] best_idx;
  logic [DATA_W-1:0] best_diff;
  logic              err_overflow;

  rank_sequencer #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .NUM_ENTRIES (NUM_E)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_ready     (in_ready),
    .sub_de       (sub_de),
    .sub_x        (sub_x),
    .sub_y        (sub_y),
    .sub_bin      (sub_bin),
    .sub_oe       (sub_oe),
    .sub_diff     (sub_diff),
    .sub_bout     (sub_bout),
    .mem_cs       (mem_cs),
    .mem_rw_      (mem_rw_),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .best_idx     (best_idx),
    .best_diff    (best_diff),
    .err_overflow (err_overflow)
  );

  // Standalone magnitude block, checked against hand-computed constants.
  logic [DATA_W-1:0] ad_diff;
  logic              ad_bout;
  logic [DATA_W-1:0] ad_abs;

  abs_diff #(.DATA_W(DATA_W)) u_ref_abs (
    .i_diff (ad_diff),
    .i_bout (ad_bout),
    .o_abs  (ad_abs)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_acc;
  int  exp_best_diff;
  int  exp_best_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Subtractor model: one cycle from sub_de low to sub_oe low.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      sub_oe   <= 1'b1;
      sub_diff <= '0;
      sub_bout <= 1'b0;
    end else begin
      sub_oe   <= sub_de;
      sub_diff <= sub_x - sub_y;
      sub_bout <= (sub_x < sub_y);
    end
  end

  // Memory model: synchronous write, read data one cycle after the read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge CLK) begin
    if (mem_cs) begin
      if (!mem_rw_) mem[mem_addr] <= mem_wdata;
      else          mem_rdata     <= mem[mem_addr];
    end
  end

  // Write scoreboard and done-pulse counter, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (done) done_cnt++;
      if (mem_cs && !mem_rw_) begin
        if (exp_q.size() == 0) begin
          check("spurious_write_addr", {26'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", {26'd0, mem_addr}, {26'd0, e.addr});
          check("write_data", {20'd0, mem_wdata}, {20'd0, e.data});
        end
      end
    end
  end

  task automatic reset_model();
    exp_q.delete();
    n_acc         = 0;
    exp_best_diff = (1 << DATA_W) - 1;
    exp_best_idx  = 0;
  endtask

  task automatic start_frame();
    reset_model();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Present one pair and hold it until accepted (bounded).
  task automatic send_pair(input int x, input int y, input logic last);
    int budget;
    int a;
    wr_t e;
    budget = 0;
    @(negedge CLK);
    in_valid = 1'b1;
    in_x     = DATA_W'(x);
    in_y     = DATA_W'(y);
    in_last  = last;
    while (!in_ready && budget < 50) begin
      @(negedge CLK);
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      a      = (x > y) ? (x - y) : (y - x);
      e.addr = ADDR_W'(n_acc);
      e.data = DATA_W'(a);
      exp_q.push_back(e);
      if (a < exp_best_diff) begin
        exp_best_diff = a;
        exp_best_idx  = n_acc;
      end
      n_acc++;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int budget;
    budget = 0;
    while (!done && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    check({tag, "_done"},      {31'd0, done},         32'd1);
    check({tag, "_best_idx"},  {26'd0, best_idx},     32'(exp_best_idx));
    check({tag, "_best_diff"}, {20'd0, best_diff},    32'(exp_best_diff));
    check({tag, "_err"},       {31'd0, err_overflow}, {31'd0, exp_err});
    check({tag, "_busy"},      {31'd0, busy},         32'd0);
    check({tag, "_writes"},    32'(exp_q.size()),     32'd0);
    @(negedge CLK);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sub_de"},    {31'd0, sub_de},       32'd1);
    check({tag, "_sub_x"},     {20'd0, sub_x},        32'd0);
    check({tag, "_sub_y"},     {20'd0, sub_y},        32'd0);
    check({tag, "_sub_bin"},   {31'd0, sub_bin},      32'd0);
    check({tag, "_mem_cs"},    {31'd0, mem_cs},       32'd0);
    check({tag, "_mem_rw_"},   {31'd0, mem_rw_},      32'd1);
    check({tag, "_mem_addr"},  {26'd0, mem_addr},     32'd0);
    check({tag, "_mem_wdata"}, {20'd0, mem_wdata},    32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready},     32'd0);
    check({tag, "_busy"},      {31'd0, busy},         32'd0);
    check({tag, "_done"},      {31'd0, done},         32'd0);
    check({tag, "_best_idx"},  {26'd0, best_idx},     32'd0);
    check({tag, "_best_diff"}, {20'd0, best_diff},    32'd0);
    check({tag, "_err"},       {31'd0, err_overflow}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int snap;
    int budget;
    RST      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_x     = '0;
    in_y     = '0;
    ad_diff  = '0;
    ad_bout  = 1'b0;
    reset_model();

    // Reset state
    repeat (2) @(negedge CLK);
    check_reset_outputs("por");
    RST = 1'b0;

    // Magnitude block on its own
    ad_diff = 12'd5;    ad_bout = 1'b0; #1; check("abs_pos",     {20'd0, ad_abs}, 32'd5);
    ad_diff = 12'd4092; ad_bout = 1'b1; #1; check("abs_neg4",    {20'd0, ad_abs}, 32'd4);
    ad_diff = 12'd1;    ad_bout = 1'b1; #1; check("abs_neg4095", {20'd0, ad_abs}, 32'd4095);
    ad_diff = 12'd0;    ad_bout = 1'b1; #1; check("abs_wrap0",   {20'd0, ad_abs}, 32'd0);

    // Basic frame
    start_frame();
    check("basic_busy", {31'd0, busy}, 32'd1);
    send_pair(2, 1, 1'b0);
    send_pair(5, 9, 1'b0);
    send_pair(7, 7, 1'b1);
    check("basic_ready_drop", {31'd0, in_ready}, 32'd0);
    wait_done("basic", 1'b0);

    // Tie keeps the lower index
    start_frame();
    send_pair(3, 1, 1'b0);
    send_pair(1, 3, 1'b1);
    wait_done("tie", 1'b0);

    // Overflow: four pairs without last, fifth must be refused
    start_frame();
    send_pair(20, 5, 1'b0);
    send_pair(3, 10, 1'b0);
    send_pair(8, 1, 1'b0);
    send_pair(50, 60, 1'b0);
    @(negedge CLK);
    in_valid = 1'b1;
    in_x     = '0;
    in_y     = '0;
    for (int i = 0; i < 3; i++) begin
      check("ovf_fifth_refused", {31'd0, in_ready}, 32'd0);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    wait_done("ovf", 1'b1);

    // Gaps in in_valid, large negative difference
    start_frame();
    send_pair(10, 4, 1'b0);
    repeat (2) @(negedge CLK);
    send_pair(0, 4095, 1'b1);
    wait_done("gap", 1'b0);

    // Asynchronous reset mid-LOAD
    start_frame();
    send_pair(1, 2, 1'b0);
    send_pair(3, 4, 1'b0);
    snap = done_cnt;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("midload");
    reset_model();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("midload_no_done", 32'(done_cnt - snap), 32'd0);
    start_frame();
    send_pair(9, 9, 1'b1);
    wait_done("after_rst", 1'b0);

    // start pulsed during SCAN is ignored
    snap = done_cnt;
    start_frame();
    send_pair(6, 2, 1'b0);
    send_pair(9, 4, 1'b0);
    send_pair(1, 3, 1'b1);
    budget = 0;
    while (!(mem_cs && mem_rw_) && budget < 50) begin
      @(negedge CLK);
      budget++;
    end
    check("scan_read_seen", {31'd0, mem_cs && mem_rw_}, 32'd1);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done("busy_start", 1'b0);
    repeat (10) @(negedge CLK);
    check("busy_start_one_done", 32'(done_cnt - snap), 32'd1);
    check("busy_start_idle",     {31'd0, busy},        32'd0);
    check("busy_start_ready",    {31'd0, in_ready},    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rank_sequencer.md
Name: rank_sequencer

Overview:
Controller for the alphabet ranking datapath. It accepts a stream of (X, Y) feature/template pairs, sequences them through subtractor_module, and writes each absolute difference to memory at consecutive addresses. End of input is signalled by in_last, not by elapsed time. It then scans memory and reports the index and value of the minimum difference, which is the best-matching alphabet.

Parameters:
DATA_W, 12, width of X/Y/DIFF and stored words
ADDR_W, 6, memory address width
NUM_ENTRIES, 26, maximum pairs per frame (alphabet count); must be ≤ 2**ADDR_W

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-high reset
start  in  1  begin a frame; honoured only in IDLE
in_valid  in  1  in_x/in_y/in_last valid
in_last  in  1  final pair of frame; qualified by in_valid
in_x  in  DATA_W  feature value
in_y  in  DATA_W  template value
in_ready  out  1  pair accepted when in_valid & in_ready
sub_de  out  1  subtractor enable, active-low (0 = compute)
sub_x  out  DATA_W  subtractor X
sub_y  out  DATA_W  subtractor Y
sub_bin  out  1  borrow-in, tied 0
sub_oe  in  1  subtractor result valid, active-low
sub_diff  in  DATA_W  X−Y modulo 2**DATA_W
sub_bout  in  1  borrow-out (X<Y)
mem_cs  out  1  memory chip select, active-high
mem_rw_  out  1  1 = read, 0 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid one cycle after read issue
busy  out  1  high outside IDLE/DONE
done  out  1  one-cycle pulse at end of frame
best_idx  out  ADDR_W  index of minimum difference
best_diff  out  DATA_W  minimum difference
err_overflow  out  1  frame exceeded NUM_ENTRIES; sticky until next start

Behaviour:
- Reset (async, any state): go to IDLE. Reset values: sub_de=1, sub_x=sub_y=0, sub_bin=0, mem_cs=0, mem_rw_=1, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, best_idx=0, best_diff=0, err_overflow=0. Reset mid-frame abandons the frame; memory contents are don't-care.
- All outputs are registered.
- States: IDLE -> LOAD (on start), LOAD -> DRAIN, DRAIN -> SCAN, SCAN -> DONE, DONE -> IDLE (next cycle).
- IDLE -> LOAD on start:
  - Clear wr_idx and err_overflow.
  - Set best_diff to all-ones and best_idx to 0.
- LOAD:
  - in_ready=1.
  - On each accepted pair, register sub_x/sub_y and drive sub_de=0 for one cycle. With no accepted pair, sub_de=1.
  - Leave LOAD after accepting a pair with in_last=1, or after accepting pair NUM_ENTRIES. In the second case, set err_overflow if in_last=0 on that pair.
  - in_ready drops the cycle after the last accept. Later pairs are not accepted.
- Write path (LOAD/DRAIN):
  - When sub_oe=0, compute abs = sub_bout ? (~sub_diff + 1) : sub_diff, truncated to DATA_W.
  - Next cycle: mem_cs=1, mem_rw_=0, mem_addr=wr_idx, mem_wdata=abs; then wr_idx++.
  - One write per result, in acceptance order, at addresses 0..N−1.
- DRAIN: wait until all N writes have been issued, then go to SCAN. Subtractor latency is absorbed here; any latency ≥1 cycle is tolerated by counting results against accepts.
- SCAN:
  - Issue reads at addr 0..N−1, one per cycle (mem_cs=1, mem_rw_=1).
  - Compare each mem_rdata the cycle after its read issue.
  - Replace best only if strictly less, so ties keep the lower index.
  - Enter DONE the cycle after the final compare.
- DONE: done=1 for one cycle, then IDLE. best_idx/best_diff/err_overflow hold until the next start.
- mem_cs=0 whenever no access is issued.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.

Decomposition:
- Package rank_pkg: state enum (IDLE, LOAD, DRAIN, SCAN, DONE), default widths, MEM_READ=1 / MEM_WRITE=0 constants.
- One sub-module: abs_diff (combinational two's-complement magnitude from sub_diff/sub_bout), reused by the bench model.

Test Plan:
- Basic frame: start, pairs (2,1), (5,9), (7,7) with last on the third. Writes must be addr0=1, addr1=4, addr2=0 (mem_rw_=0, mem_cs=1). Then done pulse with best_idx=2, best_diff=0, err_overflow=0.
- Tie: pairs (3,1), (1,3) -> both stored as 2. Result best_idx=0, best_diff=2.
- Overflow (NUM_ENTRIES=4): five pairs, no last. Four writes occur, the fifth is not accepted (in_ready=0), err_overflow=1 at done, result taken over addr 0..3.
- Backpressure/gaps: in_valid toggled 1,0,0,1 with pairs (10,4), (0,4095) last. Writes must be 6 and 4095, best_idx=0, best_diff=6, no spurious writes in gap cycles.
- Reset mid-LOAD: assert RST after the second accept. All outputs at reset values immediately (async), no done pulse. A new frame (9,9) then completes with best_idx=0, best_diff=0.
- start while busy: pulse start during SCAN -> ignored; exactly one done pulse for the frame.
